// File: rtl/matadd_dispatcher.sv
// Matrix-add job dispatcher: descriptor FIFO feeding a start/done sequencer with timeout.
// Define DISPATCH_PERF_CNT_EN to add the perf_jobs / perf_last_latency counters.
module matadd_dispatcher #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_ELEMS      = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_mat1_ptr,
    input  logic [31:0] cmd_mat2_ptr,
    input  logic [31:0] cmd_out_ptr,
    input  logic [31:0] cmd_dims,
    output logic        acc_start,
    output logic [31:0] acc_mat1_ptr,
    output logic [31:0] acc_mat2_ptr,
    output logic [31:0] acc_out_ptr,
    output logic [31:0] acc_dims,
    input  logic        acc_ready,
    input  logic        acc_done,
    input  logic [31:0] acc_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_status,
    output logic        busy
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_jobs,
    output logic [15:0] perf_last_latency
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [1:0] ST_BAD_DIMS = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [127:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, push, pop;

    logic [127:0] head;
    logic [15:0]  head_rows, head_cols;
    logic [31:0]  head_elems;
    logic         head_bad;

    logic [31:0]  wait_cnt;
    logic         load_bus, set_ok, set_timeout, set_bad;

    // ---------------- command FIFO ----------------
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_mat1_ptr, cmd_mat2_ptr, cmd_out_ptr, cmd_dims};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // ---------------- head descriptor decode ----------------
    assign head       = mem[rd_ptr];
    assign head_rows  = head[31:16];
    assign head_cols  = head[15:0];
    assign head_elems = 32'(head_rows) * 32'(head_cols);
    assign head_bad   = (head_rows == '0) || (head_cols == '0) ||
                        (head_elems > 32'(MAX_ELEMS));

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        load_bus    = 1'b0;
        set_ok      = 1'b0;
        set_timeout = 1'b0;
        set_bad     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_bad) begin
                        pop       = 1'b1;
                        set_bad   = 1'b1;
                        state_nxt = RESP;
                    end else if (acc_ready) begin
                        load_bus  = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                pop       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // wait_cnt is still zero in the first WAIT cycle, masking a stale done
                if (acc_done && (wait_cnt != '0)) begin
                    set_ok    = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    set_timeout = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign acc_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE) || !empty;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_mat1_ptr <= '0;
            acc_mat2_ptr <= '0;
            acc_out_ptr  <= '0;
            acc_dims     <= '0;
            rsp_result   <= '0;
            rsp_status   <= ST_OK;
            wait_cnt     <= '0;
        end else begin
            if (load_bus) begin
                acc_mat1_ptr <= head[127:96];
                acc_mat2_ptr <= head[95:64];
                acc_out_ptr  <= head[63:32];
                acc_dims     <= head[31:0];
            end

            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 32'd1;

            if (set_ok) begin
                rsp_result <= acc_result;
                rsp_status <= ST_OK;
            end else if (set_timeout) begin
                rsp_result <= '0;
                rsp_status <= ST_TIMEOUT;
            end else if (set_bad) begin
                rsp_result <= '0;
                rsp_status <= ST_BAD_DIMS;
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    logic [15:0] lat_cnt;

    // lat_cnt equals (current cycle - start cycle) throughout WAIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_jobs         <= '0;
            perf_last_latency <= '0;
            lat_cnt           <= '0;
        end else begin
            if ((state == RESP) && rsp_ready && (rsp_status == ST_OK))
                perf_jobs <= perf_jobs + 16'd1;

            if (state == ISSUE)
                lat_cnt <= 16'd1;
            else if ((state == WAIT) && (lat_cnt != '1))
                lat_cnt <= lat_cnt + 16'd1;

            if (set_ok) perf_last_latency <= lat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_matadd_dispatcher.sv
// Scoreboard bench for matadd_dispatcher: directed jobs, accelerator model, queued expectations.
module tb_matadd_dispatcher;

    localparam int ACC_DELAY = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_mat1_ptr, cmd_mat2_ptr, cmd_out_ptr, cmd_dims;
    logic        acc_start;
    logic [31:0] acc_mat1_ptr, acc_mat2_ptr, acc_out_ptr, acc_dims;
    logic        acc_ready;
    logic        acc_done;
    logic [31:0] acc_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_status;
    logic        busy;
`ifdef DISPATCH_PERF_CNT_EN
    logic [15:0] perf_jobs, perf_last_latency;
`endif

    always #5 clk = ~clk;

    matadd_dispatcher #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16),
        .MAX_ELEMS     (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mat1_ptr(cmd_mat1_ptr),
        .cmd_mat2_ptr(cmd_mat2_ptr),
        .cmd_out_ptr (cmd_out_ptr),
        .cmd_dims    (cmd_dims),
        .acc_start   (acc_start),
        .acc_mat1_ptr(acc_mat1_ptr),
        .acc_mat2_ptr(acc_mat2_ptr),
        .acc_out_ptr (acc_out_ptr),
        .acc_dims    (acc_dims),
        .acc_ready   (acc_ready),
        .acc_done    (acc_done),
        .acc_result  (acc_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_status  (rsp_status),
        .busy        (busy)
`ifdef DISPATCH_PERF_CNT_EN
        ,
        .perf_jobs        (perf_jobs),
        .perf_last_latency(perf_last_latency)
`endif
    );

    int total = 0;
    int bad   = 0;
    int starts = 0;

    logic [33:0]  exp_q[$];   // {status, result}
    logic [127:0] iss_q[$];   // {mat1, mat2, out, dims}
    logic [31:0]  res_q[$];   // results the accelerator model returns
    logic         acc_hang = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accelerator model: done + result ACC_DELAY cycles after start unless hung at start time.
    initial begin
        int  cnt;
        logic pend, hang;
        cnt = 0; pend = 1'b0; hang = 1'b0;
        acc_done = 1'b0; acc_result = '0;
        forever begin
            @(negedge clk);
            acc_done = 1'b0;
            if (acc_start) begin
                pend = 1'b1;
                cnt  = ACC_DELAY;
                hang = acc_hang;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    if (!hang) begin
                        acc_done   = 1'b1;
                        acc_result = (res_q.size() != 0) ? res_q.pop_front() : 32'hDEAD_BEEF;
                    end
                end
            end
        end
    end

    // Monitor: checks every response handshake and every start pulse against the queues.
    initial begin
        logic [33:0]  e;
        logic [127:0] x;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_status", rsp_status, e[33:32]);
                    chk("rsp_result", rsp_result, e[31:0]);
                end
            end
            if (acc_start) begin
                starts++;
                if (iss_q.size() == 0) begin
                    chk("start_unexpected", acc_start, 1'b0);
                end else begin
                    x = iss_q.pop_front();
                    chk("acc_bus", {acc_mat1_ptr, acc_mat2_ptr, acc_out_ptr, acc_dims}, x);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_job(input logic [31:0] m1, input logic [31:0] m2,
                            input logic [31:0] o, input logic [31:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_mat1_ptr = m1; cmd_mat2_ptr = m2; cmd_out_ptr = o; cmd_dims = d;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic expect_job(input logic [31:0] m1, input logic [31:0] m2,
                              input logic [31:0] o, input logic [31:0] d,
                              input logic [31:0] res);
        iss_q.push_back({m1, m2, o, d});
        exp_q.push_back({2'b00, res});
        res_q.push_back(res);
    endtask

    task automatic wait_start(input int max);
        int n;
        n = 0;
        while (!acc_start && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_start", acc_start, 1'b1);
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_busy", busy, 1'b0);
        chk("drain_rsp_pending", exp_q.size(), 0);
        chk("drain_iss_pending", iss_q.size(), 0);
    endtask

    initial begin
        int s0;
        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_mat1_ptr = '0; cmd_mat2_ptr = '0; cmd_out_ptr = '0; cmd_dims = '0;
        acc_ready = 1'b1; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_acc_start", acc_start, 1'b0);
        chk("rst_acc_bus", {acc_mat1_ptr, acc_mat2_ptr, acc_out_ptr, acc_dims}, 128'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_status", rsp_status, 2'b00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job, start two cycles after push
        expect_job(32'h100, 32'h200, 32'h300, 32'h0004_0004, 32'd3);
        push_job(32'h100, 32'h200, 32'h300, 32'h0004_0004);
        chk("lat_cycle1_no_start", acc_start, 1'b0);
        @(negedge clk);
        chk("lat_cycle2_start", acc_start, 1'b1);
        wait_drain(60);

        // Bad dims rejected without a start; 16x16 sits exactly on the limit
        s0 = starts;
        exp_q.push_back({2'b10, 32'h0});
        exp_q.push_back({2'b10, 32'h0});
        exp_q.push_back({2'b10, 32'h0});
        expect_job(32'h1100, 32'h1200, 32'h1300, 32'h0010_0010, 32'h256);
        push_job(32'h1000, 32'h1001, 32'h1002, 32'h0000_0008);
        push_job(32'h1010, 32'h1011, 32'h1012, 32'h0011_0010);
        push_job(32'h1020, 32'h1021, 32'h1022, 32'h0008_0000);
        push_job(32'h1100, 32'h1200, 32'h1300, 32'h0010_0010);
        wait_drain(100);
        chk("bad_dims_starts", starts - s0, 1);

        // Timeout, then the queued job completes normally
        acc_hang = 1'b1;
        iss_q.push_back({32'h2100, 32'h2200, 32'h2300, 32'h0002_0003});
        exp_q.push_back({2'b01, 32'h0});
        push_job(32'h2100, 32'h2200, 32'h2300, 32'h0002_0003);
        expect_job(32'h2400, 32'h2500, 32'h2600, 32'h0003_0002, 32'h55);
        push_job(32'h2400, 32'h2500, 32'h2600, 32'h0003_0002);
        wait_start(20);
        @(negedge clk);
        acc_hang = 1'b0;
        wait_drain(120);

        // FIFO full with accelerator busy; response held under backpressure
        acc_ready = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_job(32'h3000 + i, 32'h3100 + i, 32'h3200 + i, 32'h0001_0001, 32'h10 + i);
            push_job(32'h3000 + i, 32'h3100 + i, 32'h3200 + i, 32'h0001_0001);
        end
        chk("full_cmd_ready", cmd_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        cmd_valid = 1'b1; cmd_mat1_ptr = 32'h3FFF; cmd_dims = 32'h0001_0001;
        repeat (3) @(negedge clk);
        chk("full_still_blocked", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        s0 = starts;
        acc_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        repeat (6) @(negedge clk);
        chk("bp_hold_valid", rsp_valid, 1'b1);
        chk("bp_hold_result", rsp_result, 32'h10);
        chk("bp_hold_status", rsp_status, 2'b00);
        chk("bp_one_issue", starts - s0, 1);
        rsp_ready = 1'b1;
        wait_drain(200);

        // Reset during WAIT: job abandoned, late done ignored
        iss_q.push_back({32'h4000, 32'h4100, 32'h4200, 32'h0002_0002});
        res_q.push_back(32'hBAD0);
        push_job(32'h4000, 32'h4100, 32'h4200, 32'h0002_0002);
        wait_start(10);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_acc_start", acc_start, 1'b0);
        chk("mid_rst_acc_bus", {acc_mat1_ptr, acc_mat2_ptr, acc_out_ptr, acc_dims}, 128'h0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_rsp_result", rsp_result, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        // Push during ISSUE with two queued: occupancy unchanged, order kept
        acc_ready = 1'b0;
        expect_job(32'h5000, 32'h5100, 32'h5200, 32'h0001_0002, 32'd7);
        push_job(32'h5000, 32'h5100, 32'h5200, 32'h0001_0002);
        expect_job(32'h5001, 32'h5101, 32'h5201, 32'h0001_0002, 32'd8);
        push_job(32'h5001, 32'h5101, 32'h5201, 32'h0001_0002);
        acc_ready = 1'b1;
        wait_start(10);
        expect_job(32'h5002, 32'h5102, 32'h5202, 32'h0001_0002, 32'd9);
        push_job(32'h5002, 32'h5102, 32'h5202, 32'h0001_0002);
        expect_job(32'h5003, 32'h5103, 32'h5203, 32'h0001_0002, 32'd10);
        push_job(32'h5003, 32'h5103, 32'h5203, 32'h0001_0002);
        chk("pp_one_slot_left", cmd_ready, 1'b1);
        expect_job(32'h5004, 32'h5104, 32'h5204, 32'h0001_0002, 32'd11);
        push_job(32'h5004, 32'h5104, 32'h5204, 32'h0001_0002);
        chk("pp_full_after_two", cmd_ready, 1'b0);
        wait_drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
